// File: rtl/tile_draw_engine.sv
// tile_draw_engine
// Sits between the 16x16 grid address counter and the VGA adapter. For each
// cell address it reads the cell value from BRAM port A and uses it as the
// tile colour. It then plots a WIDTH x WIDTH square at the cell's pixel
// origin, one pixel per clock. When the tile is finished it pulses done,
// which advances the counter.
//
// Build option:
//   TILE_GAP_CLEAR_EN - when defined, each tile also covers its SPACING gap.
//                       The draw loop spans (WIDTH+SPACING)^2 pixels, and gap
//                       pixels are plotted with colour 0.
module tile_draw_engine #(
  parameter int WIDTH      = 10,
  parameter int SPACING    = 2,
  parameter int DATA_W     = 3,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [8:0]        address,
  output logic [8:0]        bram_addr,
  output logic              rden,
  input  logic [DATA_W-1:0] q,
  output logic [9:0]        vga_x,
  output logic [8:0]        vga_y,
  output logic [DATA_W-1:0] vga_colour,
  output logic              plot,
  output logic              done,
  output logic              busy,
  output logic              frame_done
);

  localparam int PITCH = WIDTH + SPACING;
`ifdef TILE_GAP_CLEAR_EN
  localparam int SPAN = PITCH;
`else
  localparam int SPAN = WIDTH;
`endif
  localparam int CW = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int LW = 2;
  localparam logic [CW-1:0] LAST_POS = CW'(SPAN - 1);
  localparam logic [LW-1:0] RD_LAST  = LW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    DRAW,
    DONE
  } stateType;

  stateType          state;
  logic [LW-1:0]     readCount;
  logic [7:0]        cellAddr;
  logic [DATA_W-1:0] cellColour;
  logic [9:0]        originX;
  logic [8:0]        originY;
  logic [CW-1:0]     dx;
  logic [CW-1:0]     dy;

  logic [9:0]        latchOriginX;
  logic [8:0]        latchOriginY;
  logic              lastCol;
  logic              lastRow;
  logic [CW-1:0]     nextDx;
  logic [CW-1:0]     nextDy;
  logic              nextGap;
  logic [9:0]        nextX;
  logic [8:0]        nextY;

  // The counter supplies 9 address bits, but only the 8-bit cell index matters.
  logic unusedAddrMsb;
  assign unusedAddrMsb = address[8];

  // The counter's new address is valid in the first READ cycle. The only
  // cycle rden is high, so it is presented to the BRAM directly.
  assign bram_addr = rden ? {1'b0, address[7:0]} : 9'd0;

  assign busy = (state != IDLE);

  // The cell origin is the grid position times the tile pitch.
  assign latchOriginX = 10'(cellAddr[3:0]) * 10'(PITCH);
  assign latchOriginY = 9'(cellAddr[7:4]) * 9'(PITCH);

  // Pixel stepping: dx is the inner loop, and dy advances when dx wraps.
  // NOTE: every signal written here gets a default first, so no path can leave a latch.
  always_comb begin
    lastCol = 1'b0;
    lastRow = 1'b0;
    nextDx  = dx;
    nextDy  = dy;
    lastCol = (dx == LAST_POS);
    lastRow = (dy == LAST_POS);
    if (lastCol) begin
      nextDx = '0;
      nextDy = dy + 1'b1;
    end else begin
      nextDx = dx + 1'b1;
    end
  end

  assign nextX = originX + 10'(nextDx);
  assign nextY = originY + 9'(nextDy);

  // In gap-clear builds, pixels outside the WIDTH x WIDTH square are painted with colour 0.
`ifdef TILE_GAP_CLEAR_EN
  assign nextGap = (nextDx >= CW'(WIDTH)) || (nextDy >= CW'(WIDTH));
`else
  assign nextGap = 1'b0;
`endif

  // Tile sequencer: IDLE -> READ -> LATCH -> DRAW -> DONE, with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: datapath registers are reset along with the control registers,
      // so every output reads 0 straight out of reset.
      state      <= IDLE;
      readCount  <= '0;
      cellAddr   <= '0;
      cellColour <= '0;
      originX    <= '0;
      originY    <= '0;
      dx         <= '0;
      dy         <= '0;
      rden       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      done       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rden       <= 1'b0;
      done       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= READ;
            rden      <= 1'b1;
            readCount <= '0;
          end
        end

        READ: begin
          // The address is only guaranteed valid in the first read cycle.
          if (readCount == '0) begin
            cellAddr <= address[7:0];
          end
          if (readCount == RD_LAST) begin
            state <= LATCH;
          end else begin
            readCount <= readCount + 1'b1;
          end
        end

        LATCH: begin
          // The first pixel (0,0) is issued here, so it is visible in the first DRAW cycle.
          cellColour <= q;
          originX    <= latchOriginX;
          originY    <= latchOriginY;
          dx         <= '0;
          dy         <= '0;
          vga_x      <= latchOriginX;
          vga_y      <= latchOriginY;
          vga_colour <= q;
          plot       <= 1'b1;
          state      <= DRAW;
        end

        DRAW: begin
          if (lastCol && lastRow) begin
            plot       <= 1'b0;
            done       <= 1'b1;
            frame_done <= (cellAddr == 8'hFF);
            state      <= DONE;
          end else begin
            dx         <= nextDx;
            dy         <= nextDy;
            vga_x      <= nextX;
            vga_y      <= nextY;
            vga_colour <= nextGap ? '0 : cellColour;
          end
        end

        DONE: begin
          // The counter advances on this edge, so the next READ sees the new address with no bubble.
          if (enable) begin
            state     <= READ;
            rden      <= 1'b1;
            readCount <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_draw_engine.sv
// Self-checking bench for tile_draw_engine. A grid-counter model and a BRAM
// model surround the DUT. Expected pixels are pushed to a scoreboard queue
// when a tile is requested, and popped as the DUT plots.
module tb_tile_draw_engine;

  localparam int WIDTH      = 10;
  localparam int SPACING    = 2;
  localparam int DATA_W     = 3;
  localparam int RD_LATENCY = 2;
  localparam int PITCH      = WIDTH + SPACING;
`ifdef TILE_GAP_CLEAR_EN
  localparam int SPAN = PITCH;
`else
  localparam int SPAN = WIDTH;
`endif
  localparam int TILE_CYC = RD_LATENCY + 1 + SPAN * SPAN + 1;

  typedef struct packed {
    logic [9:0]        x;
    logic [8:0]        y;
    logic [DATA_W-1:0] c;
  } pix_t;

  typedef struct {
    logic [8:0]        addr;
    logic [DATA_W-1:0] colour;
    int                firstX;
    int                firstY;
    bit                frame;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [8:0]        address;
  logic [8:0]        bram_addr;
  logic              rden;
  logic [DATA_W-1:0] q;
  logic [9:0]        vga_x;
  logic [8:0]        vga_y;
  logic [DATA_W-1:0] vga_colour;
  logic              plot;
  logic              done;
  logic              busy;
  logic              frame_done;

  tile_draw_engine #(
    .WIDTH(WIDTH), .SPACING(SPACING), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .address(address),
    .bram_addr(bram_addr), .rden(rden), .q(q),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .done(done), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Grid address counter model: loads on request, advances on done.
  logic [7:0] cnt;
  logic       addrHi;
  logic       cntLoad;
  logic       cntEn;
  logic [7:0] loadVal;
  assign address = {addrHi, cnt};
  always @(posedge clock) begin
    if (cntLoad) cnt <= loadVal;
    else if (cntEn && done) cnt <= cnt + 8'd1;
  end

  // BRAM port A model with RD_LATENCY cycles from rden to q.
  logic [DATA_W-1:0] mem  [256];
  logic [DATA_W-1:0] pipe [RD_LATENCY];
  always @(posedge clock) begin
    if (rden) pipe[0] <= mem[bram_addr[7:0]];
    for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign q = pipe[RD_LATENCY-1];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  pix_t expQ[$];
  pix_t gotPix;
  pix_t expPix;
  int   doneCount = 0;
  int   frameCount = 0;
  int   rdenCount = 0;
  int   doneCyc = 0;
  int   tilePix = 0;
  int   lastTilePix = 0;
  int   firstX = 0;
  int   firstY = 0;
  int   lastX = 0;
  int   lastY = 0;
  logic [8:0] lastBramAddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output monitor: pixel scoreboard, pulse counters, tile bookkeeping.
  always @(negedge clock) begin
    if (plot) begin
      gotPix.x = vga_x;
      gotPix.y = vga_y;
      gotPix.c = vga_colour;
      check("scoreboard_has_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        expPix = expQ.pop_front();
        check("pixel_xyc", 32'(gotPix), 32'(expPix));
      end
      if (tilePix == 0) begin
        firstX = int'(vga_x);
        firstY = int'(vga_y);
      end
      lastX = int'(vga_x);
      lastY = int'(vga_y);
      tilePix++;
    end
    if (rden) begin
      rdenCount++;
      lastBramAddr = bram_addr;
    end
    if (frame_done) begin
      frameCount++;
      check("frame_done_with_done", 32'(done), 32'd1);
      check("frame_done_addr", 32'(lastBramAddr), 32'h0FF);
    end
    if (done) begin
      doneCount++;
      doneCyc     = cyc;
      lastTilePix = tilePix;
      tilePix     = 0;
    end else if (!busy) begin
      tilePix = 0;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic loadAddr(input logic [8:0] a);
    loadVal = a[7:0];
    addrHi  = a[8];
    cntLoad = 1'b1;
    tick();
    cntLoad = 1'b0;
  endtask

  task automatic pushTile(input logic [7:0] a);
    pix_t p;
    for (int y = 0; y < SPAN; y++) begin
      for (int x = 0; x < SPAN; x++) begin
        p.x = 10'(int'(a[3:0]) * PITCH + x);
        p.y = 9'(int'(a[7:4]) * PITCH + y);
        p.c = (x >= WIDTH || y >= WIDTH) ? '0 : mem[a];
        expQ.push_back(p);
      end
    end
  endtask

  task automatic waitDone(input int budget);
    int n;
    int start;
    n = 0;
    start = doneCount;
    while (doneCount == start && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(doneCount != start), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [5];
    int   r0;
    int   f0;
    int   d0;
    int   n;
    int   startCyc;

    reset   = 1'b0;
    enable  = 1'b0;
    cntLoad = 1'b0;
    cntEn   = 1'b0;
    loadVal = '0;
    addrHi  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DATA_W'((i * 3 + 1) % 8);

    vecs[0] = '{9'h000, 3'd5, 0,   0,   1'b0};
    vecs[1] = '{9'h023, 3'd2, 36,  24,  1'b0};
    vecs[2] = '{9'h0FF, 3'd7, 180, 180, 1'b1};
    vecs[3] = '{9'h1F0, 3'd4, 0,   180, 1'b0};
    vecs[4] = '{9'h00F, 3'd1, 180, 0,   1'b0};

    // Reset state.
    loadAddr(9'h000);
    repeat (3) tick();
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_rden", 32'(rden), 32'd0);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    check("rst_vga_y", 32'(vga_y), 32'd0);
    check("rst_vga_colour", 32'(vga_colour), 32'd0);
    reset = 1'b1;
    tick();

    // Single tiles from the vector table.
    for (int i = 0; i < 5; i++) begin
      loadAddr(vecs[i].addr);
      mem[vecs[i].addr[7:0]] = vecs[i].colour;
      pushTile(vecs[i].addr[7:0]);
      r0 = rdenCount;
      f0 = frameCount;
      enable = 1'b1;
      startCyc = cyc;
      waitDone(TILE_CYC + 20);
      enable = 1'b0;
      check("tile_cycles", 32'(doneCyc - startCyc), 32'(TILE_CYC));
      check("first_x", 32'(firstX), 32'(vecs[i].firstX));
      check("first_y", 32'(firstY), 32'(vecs[i].firstY));
      check("last_x", 32'(lastX), 32'(vecs[i].firstX + SPAN - 1));
      check("last_y", 32'(lastY), 32'(vecs[i].firstY + SPAN - 1));
      check("pixel_count", 32'(lastTilePix), 32'(SPAN * SPAN));
      check("rden_cycles", 32'(rdenCount - r0), 32'd1);
      check("bram_addr", 32'(lastBramAddr), 32'({1'b0, vecs[i].addr[7:0]}));
      check("frame_done_count", 32'(frameCount - f0), 32'(vecs[i].frame));
      check("busy_in_done", 32'(busy), 32'd1);
      tick();
      check("idle_after_tile", 32'(busy), 32'd0);
      check("queue_drained", 32'(expQ.size()), 32'd0);
    end

    // enable dropped mid-DRAW of tile 5: tile completes, then IDLE, and 6 is never read.
    loadAddr(9'h005);
    cntEn = 1'b1;
    pushTile(8'h05);
    r0 = rdenCount;
    d0 = doneCount;
    enable = 1'b1;
    repeat (RD_LATENCY + 1 + 20) tick();
    check("drop_busy_mid_draw", 32'(busy), 32'd1);
    check("drop_plot_mid_draw", 32'(plot), 32'd1);
    enable = 1'b0;
    waitDone(TILE_CYC);
    check("drop_pixel_count", 32'(lastTilePix), 32'(SPAN * SPAN));
    repeat (4) tick();
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_done_once", 32'(doneCount - d0), 32'd1);
    check("drop_no_next_read", 32'(rdenCount - r0), 32'd1);
    check("drop_bram_addr", 32'(lastBramAddr), 32'h005);
    check("drop_queue_drained", 32'(expQ.size()), 32'd0);
    cntEn = 1'b0;

    // Reset asserted mid-DRAW: tile abandoned, then restart on the same address.
    loadAddr(9'h007);
    pushTile(8'h07);
    d0 = doneCount;
    enable = 1'b1;
    repeat (30) tick();
    check("rstmid_plot_before", 32'(plot), 32'd1);
    reset = 1'b0;
    enable = 1'b0;
    tick();
    check("rstmid_plot", 32'(plot), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    expQ.delete();
    reset = 1'b1;
    tick();
    check("rstmid_no_done", 32'(doneCount - d0), 32'd0);
    pushTile(8'h07);
    r0 = rdenCount;
    enable = 1'b1;
    startCyc = cyc;
    waitDone(TILE_CYC + 20);
    enable = 1'b0;
    check("rstmid_tile_cycles", 32'(doneCyc - startCyc), 32'(TILE_CYC));
    check("rstmid_pixel_count", 32'(lastTilePix), 32'(SPAN * SPAN));
    check("rstmid_bram_addr", 32'(lastBramAddr), 32'h007);
    check("rstmid_rden_cycles", 32'(rdenCount - r0), 32'd1);
    tick();
    check("rstmid_queue_drained", 32'(expQ.size()), 32'd0);

    // Full frame with the counter connected, then the wrap back to tile 0.
    loadAddr(9'h000);
    for (int t = 0; t < 257; t++) pushTile(8'(t));
    d0 = doneCount;
    f0 = frameCount;
    cntEn = 1'b1;
    enable = 1'b1;
    startCyc = cyc;
    n = 0;
    while (doneCount - d0 < 256 && n < 256 * TILE_CYC + 100) begin
      tick();
      n++;
    end
    check("frame_tiles", 32'(doneCount - d0), 32'd256);
    check("frame_cycles", 32'(doneCyc - startCyc), 32'(256 * TILE_CYC));
    check("frame_pulses", 32'(frameCount - f0), 32'd1);
    waitDone(TILE_CYC + 20);
    enable = 1'b0;
    check("wrap_first_x", 32'(firstX), 32'd0);
    check("wrap_first_y", 32'(firstY), 32'd0);
    check("wrap_frame_pulses", 32'(frameCount - f0), 32'd1);
    tick();
    cntEn = 1'b0;
    check("frame_queue_drained", 32'(expQ.size()), 32'd0);
    check("frame_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
